// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU execute controller: opcodes,
// flag positions, instruction field positions and the sequencing states.
package alu_pkg;

    localparam int NREGS = 16;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int FW    = 5;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_LSH  = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_ADDU = 4'h6;
    localparam logic [3:0] OP_ADDC = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h8;
    localparam logic [3:0] OP_SUB  = 4'h9;
    localparam logic [3:0] OP_SUBC = 4'hA;
    localparam logic [3:0] OP_CMP  = 4'hB;
    localparam logic [3:0] OP_ASHU = 4'hC;
    localparam logic [3:0] OP_MOV  = 4'hD;
    localparam logic [3:0] OP_RSH  = 4'hE;
    localparam logic [3:0] OP_ALSH = 4'hF;

    localparam int FLAG_Z = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_O = 2;
    localparam int FLAG_L = 1;
    localparam int FLAG_N = 0;

    localparam int OP_MSB     = 15;
    localparam int OP_LSB     = 12;
    localparam int RD_MSB     = 11;
    localparam int RD_LSB     = 8;
    localparam int IMMSEL_BIT = 7;
    localparam int IMM_MSB    = 6;
    localparam int RS_MSB     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

    // Logical ops and ADDU treat the immediate as unsigned; everything else sign-extends.
    function automatic logic [DW-1:0] extendImm(input logic [3:0] op, input logic [6:0] imm7);
        if (op == OP_ADDU || op == OP_AND || op == OP_OR || op == OP_XOR)
            return {9'b0, imm7};
        return {{9{imm7[6]}}, imm7};
    endfunction

    function automatic logic writesReg(input logic [3:0] op);
        return !(op == OP_NOP || op == OP_CMP);
    endfunction

    function automatic logic updatesCarryOvf(input logic [3:0] op);
        return (op == OP_ADD || op == OP_ADDC || op == OP_SUB || op == OP_SUBC);
    endfunction

endpackage

// File: rtl/regfile.sv
// 16x16 register file: two asynchronous read ports, a debug read port and one
// synchronous write port; the whole array clears while rst_n is low.
module regfile
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o,
    input  logic [AW-1:0] dbg_addr_i,
    output logic [DW-1:0] dbg_data_o,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i
);

    logic [DW-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = mem_q[raddr_a_i];
    assign rdata_b_o  = mem_q[raddr_b_i];
    assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Sequences one register/immediate instruction at a time through an external
// combinational ALU: IDLE -> READ -> EXEC -> WB, with writeback and PSR upkeep.
module alu_exec_ctrl
    import alu_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    input  logic [15:0]   instr,
    output logic          instr_ready,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    output logic          alu_cin,
    input  logic [DW-1:0] alu_c,
    input  logic [FW-1:0] alu_flags,
    output logic          done,
    output logic [DW-1:0] result,
    output logic [FW-1:0] psr,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data
);

    state_e        state_q, state_d;
    logic [15:0]   instr_q, instr_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [3:0]    alu_op_q, alu_op_d;
    logic [DW-1:0] alu_res_q, alu_res_d;
    logic [FW-1:0] alu_flags_q, alu_flags_d;
    logic [DW-1:0] result_q, result_d;
    logic [FW-1:0] psr_q, psr_d;
    logic          done_q, done_d;

    logic [3:0]    op;
    logic [AW-1:0] rdest;
    logic [AW-1:0] rsrc;
    logic          immSel;
    logic [6:0]    imm7;
    logic [DW-1:0] rdataA, rdataB;
    logic [DW-1:0] operandA, operandB;
    logic          regWe;
    logic [DW-1:0] wbData;

    assign op     = instr_q[OP_MSB:OP_LSB];
    assign rdest  = instr_q[RD_MSB:RD_LSB];
    assign rsrc   = instr_q[RS_MSB:0];
    assign immSel = instr_q[IMMSEL_BIT];
    assign imm7   = instr_q[IMM_MSB:0];

    regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .raddr_a_i  (rdest),
        .rdata_a_o  (rdataA),
        .raddr_b_i  (rsrc),
        .rdata_b_o  (rdataB),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data),
        .we_i       (regWe),
        .waddr_i    (rdest),
        .wdata_i    (wbData)
    );

    // NOT is unary and operates on operand B, so B is steered onto the A input too.
    assign operandB = immSel ? extendImm(op, imm7) : rdataB;
    assign operandA = (op == OP_NOT) ? operandB : rdataA;

    // MOV bypasses the ALU and writes the operand it was given.
    assign wbData = (alu_op_q == OP_MOV) ? alu_b_q : alu_res_q;
    assign regWe  = (state_q == ST_WB) && writesReg(op);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            instr_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= OP_NOP;
            alu_res_q   <= '0;
            alu_flags_q <= '0;
            result_q    <= '0;
            psr_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            alu_res_q   <= alu_res_d;
            alu_flags_q <= alu_flags_d;
            result_q    <= result_d;
            psr_q       <= psr_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        alu_res_d   = alu_res_q;
        alu_flags_d = alu_flags_q;
        result_d    = result_q;
        psr_d       = psr_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                alu_a_d  = operandA;
                alu_b_d  = operandB;
                alu_op_d = op;
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                alu_res_d   = alu_c;
                alu_flags_d = alu_flags;
                state_d     = ST_WB;
            end
            ST_WB: begin
                result_d = writesReg(op) ? wbData : alu_res_q;
                done_d   = 1'b1;
                if (updatesCarryOvf(op)) begin
                    psr_d[FLAG_C] = alu_flags_q[FLAG_C];
                    psr_d[FLAG_O] = alu_flags_q[FLAG_O];
                end
                if (op == OP_CMP) begin
                    psr_d[FLAG_Z] = alu_flags_q[FLAG_Z];
                    psr_d[FLAG_L] = alu_flags_q[FLAG_L];
                    psr_d[FLAG_N] = alu_flags_q[FLAG_N];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign alu_cin     = psr_q[FLAG_C];
    assign done        = done_q;
    assign result      = result_q;
    assign psr         = psr_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: a behavioural ALU closes the loop, a vector table
// feeds a scoreboard queue, and hand sequences cover reset and abort cases.
module tb_alu_exec_ctrl;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] expResult;
        logic [4:0]  expPsr;
        logic [15:0] expReg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_a, alu_b, alu_c;
    logic [3:0]  alu_op;
    logic        alu_cin;
    logic [4:0]  alu_flags;
    logic        done;
    logic [15:0] result;
    logic [4:0]  psr;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   lastAcceptCyc = 0;
    vec_t vecs[22];
    vec_t expQ[$];

    alu_exec_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_cin     (alu_cin),
        .alu_c       (alu_c),
        .alu_flags   (alu_flags),
        .done        (done),
        .result      (result),
        .psr         (psr),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Cycle counter and accept-edge timestamp used for the latency check.
    always @(posedge clk) begin
        if (instr_valid && instr_ready && rst_n)
            lastAcceptCyc = cyc + 1;
        cyc = cyc + 1;
    end

    // Reference ALU: wrap-around arithmetic, flags {Z,C,O,L,N}.
    logic [16:0] addFull, subFull;
    logic        isSub;
    always_comb begin
        addFull   = {1'b0, alu_a} + {1'b0, alu_b} + ((alu_op == 4'h7) ? {16'b0, alu_cin} : 17'b0);
        subFull   = {1'b0, alu_a} - {1'b0, alu_b} - ((alu_op == 4'hA) ? {16'b0, alu_cin} : 17'b0);
        isSub     = (alu_op == 4'h9) || (alu_op == 4'hA) || (alu_op == 4'hB);
        alu_c     = 16'h0000;
        alu_flags = 5'b0;
        case (alu_op)
            4'h1: alu_c = alu_a & alu_b;
            4'h2: alu_c = alu_a | alu_b;
            4'h3: alu_c = alu_a ^ alu_b;
            4'h4: alu_c = alu_a << alu_b[3:0];
            4'h5, 4'h6, 4'h7: alu_c = addFull[15:0];
            4'h8: alu_c = ~alu_a;
            4'h9, 4'hA, 4'hB: alu_c = subFull[15:0];
            4'hC: alu_c = $unsigned($signed(alu_a) >>> alu_b[3:0]);
            4'hE: alu_c = alu_a >> alu_b[3:0];
            4'hF: alu_c = alu_a << alu_b[3:0];
            default: alu_c = 16'h0000;
        endcase
        alu_flags[4] = (alu_a == alu_b);
        alu_flags[1] = (alu_a < alu_b);
        alu_flags[0] = ($signed(alu_a) < $signed(alu_b));
        if (isSub) begin
            alu_flags[3] = subFull[16];
            alu_flags[2] = (alu_a[15] != alu_b[15]) && (subFull[15] != alu_a[15]);
        end else begin
            alu_flags[3] = addFull[16];
            alu_flags[2] = (alu_a[15] == alu_b[15]) && (addFull[15] != alu_a[15]);
        end
    end

    task automatic checkVal(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller is at a negedge; offer the instruction and record its expectation.
    task automatic applyStimulus(input vec_t v);
        int tries = 0;
        instr       = v.instr;
        instr_valid = 1'b1;
        while (!instr_ready && tries < 10) begin
            @(negedge clk);
            tries++;
        end
        checkVal("acceptReady", {15'b0, instr_ready}, 16'h0001);
        expQ.push_back(v);
        @(posedge clk);
    endtask

    // Scribble on instr while busy, then compare the writeback against the queue head.
    task automatic checkOutput();
        vec_t e;
        bit   seen = 1'b0;
        e = expQ.pop_front();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            instr = 16'($urandom);
        end
        if (!seen) begin
            total++;
            bad++;
            $display("[TB] FAIL doneTimeout: got no done expected done for instr %h", e.instr);
        end else begin
            checkVal("latency", 16'(cyc - lastAcceptCyc), 16'd3);
            checkVal("result", result, e.expResult);
            checkVal("psr", {11'b0, psr}, {11'b0, e.expPsr});
            dbg_addr = e.instr[11:8];
            #1;
            checkVal("regfile", dbg_data, e.expReg);
            checkVal("readyAfterDone", {15'b0, instr_ready}, 16'h0001);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit   doneSeen;
        vec_t post;

        vecs[0]  = '{16'h5185, 16'h0005, 5'h00, 16'h0005};
        vecs[1]  = '{16'hD2FF, 16'hFFFF, 5'h00, 16'hFFFF};
        vecs[2]  = '{16'hE281, 16'h7FFF, 5'h00, 16'h7FFF};
        vecs[3]  = '{16'h5202, 16'hFFFE, 5'h04, 16'hFFFE};
        vecs[4]  = '{16'hD3FF, 16'hFFFF, 5'h04, 16'hFFFF};
        vecs[5]  = '{16'h7381, 16'h0000, 5'h08, 16'h0000};
        vecs[6]  = '{16'hD483, 16'h0003, 5'h08, 16'h0003};
        vecs[7]  = '{16'h6583, 16'h0003, 5'h08, 16'h0003};
        vecs[8]  = '{16'hB405, 16'h0000, 5'h18, 16'h0003};
        vecs[9]  = '{16'hD6FF, 16'hFFFF, 5'h18, 16'hFFFF};
        vecs[10] = '{16'h8706, 16'h0000, 5'h18, 16'h0000};
        vecs[11] = '{16'hB102, 16'h0007, 5'h0A, 16'h0005};
        vecs[12] = '{16'h9187, 16'hFFFE, 5'h0A, 16'hFFFE};
        vecs[13] = '{16'hA101, 16'hFFFF, 5'h0A, 16'hFFFF};
        vecs[14] = '{16'h11FF, 16'h007F, 5'h0A, 16'h007F};
        vecs[15] = '{16'h318F, 16'h0070, 5'h0A, 16'h0070};
        vecs[16] = '{16'h2104, 16'h0073, 5'h0A, 16'h0073};
        vecs[17] = '{16'h4184, 16'h0730, 5'h0A, 16'h0730};
        vecs[18] = '{16'h0000, 16'h0000, 5'h0A, 16'h0000};
        vecs[19] = '{16'hC281, 16'hFFFF, 5'h0A, 16'hFFFF};
        vecs[20] = '{16'hF582, 16'h000C, 5'h0A, 16'h000C};
        vecs[21] = '{16'h5281, 16'h0000, 5'h0A, 16'h0000};

        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 4'h0;
        #1;
        checkVal("rstReady", {15'b0, instr_ready}, 16'h0001);
        checkVal("rstDone", {15'b0, done}, 16'h0000);
        checkVal("rstPsr", {11'b0, psr}, 16'h0000);
        checkVal("rstAluA", alu_a, 16'h0000);
        checkVal("rstAluB", alu_b, 16'h0000);
        checkVal("rstAluOp", {12'b0, alu_op}, 16'h0000);
        checkVal("rstResult", result, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkVal("readyAfterRelease", {15'b0, instr_ready}, 16'h0001);

        // instr_valid stays high across the whole table: back-to-back issue.
        for (int i = 0; i < 22; i++) begin
            applyStimulus(vecs[i]);
            checkOutput();
        end

        instr_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("idleWithoutValid", {15'b0, instr_ready}, 16'h0001);

        // Abort an ADD to R8 while it sits in EXEC.
        instr       = 16'h5885;
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        checkVal("busyInExec", {15'b0, instr_ready}, 16'h0000);
        rst_n = 1'b0;
        #1;
        checkVal("abortDone", {15'b0, done}, 16'h0000);
        checkVal("abortPsr", {11'b0, psr}, 16'h0000);
        checkVal("abortReady", {15'b0, instr_ready}, 16'h0001);
        checkVal("abortAluOp", {12'b0, alu_op}, 16'h0000);
        doneSeen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            doneSeen |= done;
        end
        checkVal("noDoneAfterAbort", {15'b0, doneSeen}, 16'h0000);
        checkVal("readyAfterAbort", {15'b0, instr_ready}, 16'h0001);
        checkVal("psrAfterAbort", {11'b0, psr}, 16'h0000);
        dbg_addr = 4'h8;
        #1;
        checkVal("r8Untouched", dbg_data, 16'h0000);
        dbg_addr = 4'h1;
        #1;
        checkVal("r1Cleared", dbg_data, 16'h0000);

        post = '{16'h5185, 16'h0005, 5'h00, 16'h0005};
        applyStimulus(post);
        checkOutput();
        instr_valid = 1'b0;
        @(negedge clk);
        checkVal("donePulseOneCycle", {15'b0, done}, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
